// File: rtl/pll_lock_reset_seq_if.sv
// Board reset-sequencer bundle: PLL lock in, sequenced resets and loss diagnostics out.
// slave is the sequencer side, master is the board/diagnostics side.
interface pll_lock_reset_seq_if;
  logic       locked;
  logic       lock_lost_clr;
  logic       periph_reset;
  logic       cpu_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] loss_count;

  modport master (
    output locked,
    output lock_lost_clr,
    input  periph_reset,
    input  cpu_reset_n,
    input  ready,
    input  lock_lost,
    input  loss_count
  );

  modport slave (
    input  locked,
    input  lock_lost_clr,
    output periph_reset,
    output cpu_reset_n,
    output ready,
    output lock_lost,
    output loss_count
  );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// PLL-lock driven reset sequencer: filter lock, release peripherals, then the Z180 after a further hold.
// Lock reaches the FSM 2 edges after sampling; outputs are registered from next state; no backpressure.
module pll_lock_reset_seq #(
  parameter int LOCK_FILTER = 16,
  parameter int PERIPH_HOLD = 1024,
  parameter int CPU_HOLD    = 256,
  parameter int CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  pll_lock_reset_seq_if.slave bus
);

  localparam logic [2:0] ST_WAIT_LOCK   = 3'd0;
  localparam logic [2:0] ST_FILTER      = 3'd1;
  localparam logic [2:0] ST_HOLD_PERIPH = 3'd2;
  localparam logic [2:0] ST_HOLD_CPU    = 3'd3;
  localparam logic [2:0] ST_RUN         = 3'd4;

  // A limit of exactly 2^CNT_W truncates to zero, which the counter hits by wrapping after 2^CNT_W cycles.
  localparam logic [CNT_W-1:0] FILTER_LIM = CNT_W'(LOCK_FILTER);
  localparam logic [CNT_W-1:0] PERIPH_LIM = CNT_W'(PERIPH_HOLD);
  localparam logic [CNT_W-1:0] CPU_LIM    = CNT_W'(CPU_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             lock_meta;
  logic             lock_s;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             run_loss;

  logic             periph_reset_q;
  logic             cpu_reset_n_q;
  logic             ready_q;
  logic             lock_lost_q;
  logic [7:0]       loss_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    run_loss  = 1'b0;
    case (state)
      ST_WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) begin
          state_nxt = ST_FILTER;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_FILTER: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == FILTER_LIM) begin
          state_nxt = ST_HOLD_PERIPH;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HOLD_PERIPH: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == PERIPH_LIM) begin
          state_nxt = ST_HOLD_CPU;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HOLD_CPU: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CPU_LIM) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          run_loss  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_WAIT_LOCK;
      cnt            <= '0;
      periph_reset_q <= 1'b1;
      cpu_reset_n_q  <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      periph_reset_q <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_FILTER) ||
                        (state_nxt == ST_HOLD_PERIPH);
      cpu_reset_n_q  <= (state_nxt == ST_RUN);
      ready_q        <= (state_nxt == ST_RUN);
    end
  end

  // A loss on the same edge as a clear request keeps the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_lost_q  <= 1'b0;
      loss_count_q <= 8'd0;
    end else begin
      if (run_loss) begin
        lock_lost_q <= 1'b1;
      end else if (bus.lock_lost_clr) begin
        lock_lost_q <= 1'b0;
      end
      if (run_loss && (loss_count_q != 8'hFF)) begin
        loss_count_q <= loss_count_q + 8'd1;
      end
    end
  end

  assign bus.periph_reset = periph_reset_q;
  assign bus.cpu_reset_n  = cpu_reset_n_q;
  assign bus.ready        = ready_q;
  assign bus.lock_lost    = lock_lost_q;
  assign bus.loss_count   = loss_count_q;

endmodule
